// File: rtl/i2c_cmd_assembler_if.sv
// rtl/i2c_cmd_assembler_if.sv - I2C byte stream, tx read-back and AHB request signals of the command assembler
interface i2c_cmd_assembler_if;
  logic [7:0]  rx_byte_i;
  logic        rx_valid_i;
  logic        frame_start_i;
  logic        frame_stop_i;
  logic        tx_req_i;
  logic [7:0]  tx_byte_o;
  logic        tx_valid_o;
  logic [31:0] ahb_waddr_o;
  logic [31:0] ahb_raddr_o;
  logic [31:0] ahb_wdata_o;
  logic        w_valid_o;
  logic        r_valid_o;
  logic        ahb_done_i;
  logic [31:0] ahb_rdata_i;
  logic        busy_o;
  logic        err_o;

  modport slave (
    input  rx_byte_i, rx_valid_i, frame_start_i, frame_stop_i, tx_req_i,
    input  ahb_done_i, ahb_rdata_i,
    output tx_byte_o, tx_valid_o, ahb_waddr_o, ahb_raddr_o, ahb_wdata_o,
    output w_valid_o, r_valid_o, busy_o, err_o
  );

  modport master (
    output rx_byte_i, rx_valid_i, frame_start_i, frame_stop_i, tx_req_i,
    output ahb_done_i, ahb_rdata_i,
    input  tx_byte_o, tx_valid_o, ahb_waddr_o, ahb_raddr_o, ahb_wdata_o,
    input  w_valid_o, r_valid_o, busy_o, err_o
  );
endinterface

// File: rtl/i2c_cmd_assembler.sv
// rtl/i2c_cmd_assembler.sv - assembles I2C opcode/address/data bytes into AHB read/write requests
// Optional inter-byte timeout enabled by defining I2C_CMD_TIMEOUT_EN.
module i2c_cmd_assembler #(
  parameter logic [7:0] OPC_WRITE      = 8'h01,
  parameter logic [7:0] OPC_READ       = 8'h02,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input logic                   HCLK,
  input logic                   HRESETN,
  i2c_cmd_assembler_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE, OPC, ADDR, WDATA, ISSUE_W, ISSUE_R, TX, ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_read_q, is_read_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] txbuf_q, txbuf_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        err_q, err_d;
  logic        in_frame;

  assign in_frame = (state_q == OPC) || (state_q == ADDR) || (state_q == WDATA);

`ifdef I2C_CMD_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap_q, gap_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txbuf_q   <= '0;
      tx_idx_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      txbuf_q   <= txbuf_d;
      tx_idx_q  <= tx_idx_d;
      err_q     <= err_d;
    end
  end

`ifdef I2C_CMD_TIMEOUT_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETN) gap_q <= '0;
    else          gap_q <= gap_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    txbuf_d   = txbuf_q;
    tx_idx_d  = tx_idx_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.frame_start_i) begin
          state_d = OPC;
          cnt_d   = '0;
        end
      end
      OPC, ADDR, WDATA: begin
        // A repeated START mid-frame restarts assembly; the byte in that cycle is dropped.
        if (bus.frame_start_i) begin
          state_d = OPC;
          cnt_d   = '0;
        end else if (bus.frame_stop_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (bus.rx_valid_i) begin
          if (state_q == OPC) begin
            if (bus.rx_byte_i == OPC_WRITE || bus.rx_byte_i == OPC_READ) begin
              is_read_d = (bus.rx_byte_i == OPC_READ);
              state_d   = ADDR;
              cnt_d     = '0;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end else if (state_q == ADDR) begin
            addr_d = {addr_q[23:0], bus.rx_byte_i};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = is_read_q ? ISSUE_R : WDATA;
          end else begin
            wdata_d = {wdata_q[23:0], bus.rx_byte_i};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = ISSUE_W;
          end
        end
      end
      ISSUE_W: begin
        err_d = bus.rx_valid_i;
        if (bus.ahb_done_i) state_d = IDLE;
      end
      ISSUE_R: begin
        err_d = bus.rx_valid_i;
        if (bus.ahb_done_i) begin
          txbuf_d  = bus.ahb_rdata_i;
          tx_idx_d = '0;
          state_d  = TX;
        end
      end
      TX: begin
        if (bus.frame_start_i) begin
          state_d = OPC;
          cnt_d   = '0;
        end else if (bus.frame_stop_i) begin
          state_d = IDLE;
        end else if (bus.tx_req_i && !tx_idx_q[2]) begin
          tx_idx_d = tx_idx_q + 3'd1;
        end
      end
      ERR: begin
        if (bus.frame_start_i) begin
          state_d = OPC;
          cnt_d   = '0;
        end else if (bus.frame_stop_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef I2C_CMD_TIMEOUT_EN
    gap_d = '0;
    if (in_frame && !bus.rx_valid_i && !bus.frame_start_i && !bus.frame_stop_i) begin
      if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    bus.w_valid_o   = (state_q == ISSUE_W);
    bus.r_valid_o   = (state_q == ISSUE_R);
    bus.busy_o      = (state_q == ISSUE_W) || (state_q == ISSUE_R);
    bus.tx_valid_o  = (state_q == TX) && !tx_idx_q[2];
    bus.tx_byte_o   = 8'hFF;
    if ((state_q == TX) && !tx_idx_q[2]) begin
      unique case (tx_idx_q[1:0])
        2'd0:    bus.tx_byte_o = txbuf_q[31:24];
        2'd1:    bus.tx_byte_o = txbuf_q[23:16];
        2'd2:    bus.tx_byte_o = txbuf_q[15:8];
        default: bus.tx_byte_o = txbuf_q[7:0];
      endcase
    end
    bus.err_o       = err_q;
    bus.ahb_waddr_o = addr_q;
    bus.ahb_raddr_o = addr_q;
    bus.ahb_wdata_o = wdata_q;
  end

endmodule
